// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle control unit:
// FSM states, ALU operations, condition codes and datapath selects.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH
    } state_e;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_ORR = 2'd3;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // flag_w[1] enables N/Z capture, flag_w[0] enables C/V capture
    typedef struct packed {
        logic [1:0] alu_op;
        logic [1:0] flag_w;
        logic       no_write;
        logic       valid;
    } alu_dec_t;

    function automatic alu_dec_t cmd_decode(
        input logic [3:0] cmd,
        input logic       s_bit
    );
        alu_dec_t d;
        d.alu_op   = ALU_ADD;
        d.flag_w   = 2'b00;
        d.no_write = 1'b0;
        d.valid    = 1'b0;
        case (cmd)
            CMD_ADD: begin
                d.alu_op = ALU_ADD;
                d.flag_w = {2{s_bit}};
                d.valid  = 1'b1;
            end
            CMD_SUB: begin
                d.alu_op = ALU_SUB;
                d.flag_w = {2{s_bit}};
                d.valid  = 1'b1;
            end
            CMD_AND: begin
                d.alu_op = ALU_AND;
                d.flag_w = {s_bit, 1'b0};
                d.valid  = 1'b1;
            end
            CMD_ORR: begin
                d.alu_op = ALU_ORR;
                d.flag_w = {s_bit, 1'b0};
                d.valid  = 1'b1;
            end
            CMD_CMP: begin
                d.alu_op   = ALU_SUB;
                d.flag_w   = 2'b11;
                d.no_write = 1'b1;
                d.valid    = 1'b1;
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/multicycle_cond_logic.sv
// Architectural NZCV flag register and ARM condition-code evaluation
// against the registered flags.
module multicycle_cond_logic
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       flag_en,
    output logic       cond_ex_next
);

    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       n;
    logic       z;
    logic       c;
    logic       v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    always_comb begin
        flags_d = flags_q;
        if (flag_en && flag_w[1]) begin
            flags_d[3:2] = alu_flags[3:2];
        end
        if (flag_en && flag_w[0]) begin
            flags_d[1:0] = alu_flags[1:0];
        end
    end

    assign {n, z, c, v} = flags_q;

    always_comb begin
        cond_ex_next = 1'b0;
        unique case (cond)
            COND_EQ: cond_ex_next = z;
            COND_NE: cond_ex_next = ~z;
            COND_CS: cond_ex_next = c;
            COND_CC: cond_ex_next = ~c;
            COND_MI: cond_ex_next = n;
            COND_PL: cond_ex_next = ~n;
            COND_VS: cond_ex_next = v;
            COND_VC: cond_ex_next = ~v;
            COND_HI: cond_ex_next = c & ~z;
            COND_LS: cond_ex_next = ~c | z;
            COND_GE: cond_ex_next = (n == v);
            COND_LT: cond_ex_next = (n != v);
            COND_GT: cond_ex_next = ~z & (n == v);
            COND_LE: cond_ex_next = z | (n != v);
            COND_AL: cond_ex_next = 1'b1;
            COND_NV: cond_ex_next = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore-style main controller for a multicycle ARM-subset datapath:
// sequences fetch/decode/execute and gates writes on the condition.
module multicycle_control_unit
    import ctrl_pkg::*;
#(
    parameter int ALUCTRL_W   = 2,
    parameter int MEM_WAIT_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           cond,
    input  logic [1:0]           op,
    input  logic [5:0]           funct,
    input  logic [3:0]           rd,
    input  logic [3:0]           alu_flags,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 adr_src,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 reg_write,
    output logic                 byte_en,
    output logic [1:0]           result_src,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           imm_src,
    output logic [1:0]           reg_src,
    output logic [ALUCTRL_W-1:0] alu_control
);

    localparam bit WAIT_ON = (MEM_WAIT_EN != 0);

    state_e   state_q;
    state_e   state_d;
    logic     cond_ex_q;
    logic     cond_ex_d;
    logic     cond_ex_next;
    logic     mem_rdy;
    logic     in_exec;
    logic     alu_wr;
    logic     flag_en;
    logic [1:0] alu_op;
    alu_dec_t dec;

    assign mem_rdy = WAIT_ON ? mem_ready : 1'b1;
    assign dec     = cmd_decode(funct[4:1], funct[0]);
    assign in_exec = (state_q == S_EXECR) || (state_q == S_EXECI);
    assign flag_en = in_exec & cond_ex_q;
    assign alu_wr  = cond_ex_q & dec.valid & ~dec.no_write;

    multicycle_cond_logic u_cond (
        .clk          (clk),
        .rst_n        (rst_n),
        .cond         (cond),
        .alu_flags    (alu_flags),
        .flag_w       (dec.flag_w),
        .flag_en      (flag_en),
        .cond_ex_next (cond_ex_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            cond_ex_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cond_ex_q <= cond_ex_d;
        end
    end

    // condition is sampled once, as the instruction leaves DECODE
    assign cond_ex_d = (state_q == S_DECODE) ? cond_ex_next : cond_ex_q;

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        byte_en    = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_op     = ALU_ADD;
        imm_src    = op;
        reg_src    = {op == OP_MEM, op == OP_BR};
        unique case (state_q)
            S_FETCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                pc_write   = mem_rdy;
                ir_write   = mem_rdy;
                if (mem_rdy) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                unique case (op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = funct[5] ? S_EXECI : S_EXECR;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_b = SRCB_IMM;
                byte_en   = funct[2];
                state_d   = funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                byte_en = funct[2];
                if (mem_rdy) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = cond_ex_q;
                byte_en    = funct[2];
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = cond_ex_q;
                byte_en   = funct[2];
                if (mem_rdy) begin
                    state_d = S_FETCH;
                end
            end
            S_EXECR: begin
                alu_src_b = SRCB_REG;
                alu_op    = dec.alu_op;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_b = SRCB_IMM;
                alu_op    = dec.alu_op;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = alu_wr;
                pc_write   = alu_wr & (rd == 4'd15);
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALU;
                pc_write   = cond_ex_q;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        alu_control      = '0;
        alu_control[1:0] = alu_op;
    end

endmodule
